// File: rtl/sw_timer.sv
// Stopwatch timebase: free-running prescaler producing a ms tick, a ms
// sub-counter, and a four-digit BCD display counter (00.00 .. 99.99).
module sw_timer #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_btn,
  input  logic        timer_on,
  input  logic        timer_clr,
  output logic        m_sec,
  output logic [15:0] bcd,
  output logic        rollover
);

  logic [15:0] r_presc;
  logic [3:0]  r_ms;
  logic [15:0] r_bcd;
  logic        r_roll;

  logic        w_presc_last;
  logic        w_advance;
  logic [15:0] w_bcd_inc;
  logic        w_carry;

  assign w_presc_last = (r_presc == 16'(CLK_DIV - 1));
  assign w_advance    = w_presc_last && timer_on;

  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      r_presc <= '0;
    end else if (w_presc_last) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Ripple the +1 through the digits; a digit at 9 (or illegal) wraps to 0.
  always_comb begin
    w_bcd_inc = r_bcd;
    w_carry   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_bcd[4*i +: 4] >= 4'd9) begin
          w_bcd_inc[4*i +: 4] = '0;
        end else begin
          w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      r_ms   <= '0;
      r_bcd  <= '0;
      r_roll <= 1'b0;
    end else if (timer_clr) begin
      r_ms   <= '0;
      r_bcd  <= '0;
      r_roll <= 1'b0;
    end else begin
      r_roll <= 1'b0;
      if (w_advance) begin
        if (r_ms >= 4'd9) begin
          r_ms   <= '0;
          r_bcd  <= w_bcd_inc;
          r_roll <= (r_bcd == 16'h9999);
        end else begin
          r_ms <= r_ms + 4'd1;
        end
      end
    end
  end

  assign m_sec    = w_presc_last;
  assign bcd      = r_bcd;
  assign rollover = r_roll;

endmodule

// File: tb/tb_sw_timer.sv
// Directed bench for sw_timer with a behavioural ms-count model checked every cycle.
module tb_sw_timer;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        on  = 1'b0;
  logic        clr = 1'b0;
  logic        m_sec;
  logic [15:0] bcd;
  logic        rollover;

  int total = 0;
  int bad   = 0;

  bit          preload_req = 1'b0;
  int unsigned preload_val = 0;

  // Model state: prescaler phase and total ms ticks counted since clear (mod 100000).
  int unsigned m_phase = 0;
  int unsigned m_total = 0;
  bit          m_roll  = 1'b0;

  sw_timer #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst_btn  (rst),
    .timer_on (on),
    .timer_clr(clr),
    .m_sec    (m_sec),
    .bcd      (bcd),
    .rollover (rollover)
  );

  always #10 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    bit tick;
    if (rst) begin
      m_phase = 0;
      m_total = 0;
      m_roll  = 1'b0;
    end else begin
      tick    = (m_phase == DIV - 1);
      m_phase = (m_phase + 1) % DIV;
      if (preload_req) begin
        m_total = preload_val;
        m_roll  = 1'b0;
      end else if (clr) begin
        m_total = 0;
        m_roll  = 1'b0;
      end else if (tick && on) begin
        m_total = (m_total + 1) % 100000;
        m_roll  = (m_total == 0);
      end else begin
        m_roll = 1'b0;
      end
    end
  end

  function automatic logic [15:0] exp_bcd(int unsigned t);
    int unsigned h;
    h = t / 10;
    return {4'((h / 1000) % 10), 4'((h / 100) % 10), 4'((h / 10) % 10), 4'(h % 10)};
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] b;
    chk("m_sec", 16'(m_sec), 16'(m_phase == DIV - 1));
    chk("bcd", bcd, exp_bcd(m_total));
    chk("rollover", 16'(rollover), 16'(m_roll));
    b = bcd;
    chk("nibble_legal", 16'((b[3:0] <= 9) && (b[7:4] <= 9) && (b[11:8] <= 9) && (b[15:12] <= 9)), 16'd1);
  endtask

  task automatic cyc(int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      check_model();
    end
  endtask

  initial begin
    bit found;

    #1 rst = 1'b1;
    #2;
    chk("rst_bcd0", bcd, 16'h0000);
    cyc(2);
    rst = 1'b0;

    for (int unsigned k = 1; k <= 8; k++) begin
      cyc(1);
      chk("phase_m_sec", 16'(m_sec), 16'((k % 4) == 3));
    end

    on = 1'b1;
    cyc(40);
    chk("count_40", bcd, 16'h0001);
    cyc(360);
    chk("count_400", bcd, 16'h0010);
    cyc(3600);
    chk("count_4000", bcd, 16'h0100);

    on  = 1'b0;
    clr = 1'b1;
    cyc(1);
    chk("clear", bcd, 16'h0000);
    clr = 1'b0;
    on  = 1'b1;
    cyc(28);
    on = 1'b0;
    cyc(20);
    chk("pause_hold", bcd, 16'h0000);
    on = 1'b1;
    cyc(12);
    chk("resume", bcd, 16'h0001);

    cyc(4880);
    chk("reach_0123", bcd, 16'h0123);
    on = 1'b0;
    found = 1'b0;
    for (int unsigned k = 0; k < 8 && !found; k++) begin
      if (m_sec) found = 1'b1;
      else cyc(1);
    end
    chk("tick_found", 16'(found), 16'd1);
    on  = 1'b1;
    clr = 1'b1;
    cyc(1);
    chk("clr_priority", bcd, 16'h0000);
    clr = 1'b0;
    on  = 1'b0;
    cyc(3);
    chk("clr_phase_kept", 16'(m_sec), 16'd1);

    // Jump the counter to 99.99 with ms=9 so the wrap fits in a short run.
    #2;
    force dut.r_bcd = 16'h9999;
    force dut.r_ms  = 4'd9;
    #1;
    release dut.r_bcd;
    release dut.r_ms;
    preload_val = 99999;
    preload_req = 1'b1;
    cyc(1);
    preload_req = 1'b0;
    chk("preload", bcd, 16'h9999);
    on = 1'b1;
    found = 1'b0;
    for (int unsigned k = 0; k < 8 && !found; k++) begin
      cyc(1);
      if (rollover) found = 1'b1;
    end
    chk("rollover_seen", 16'(found), 16'd1);
    chk("wrap_bcd", bcd, 16'h0000);
    cyc(1);
    chk("rollover_one_cycle", 16'(rollover), 16'd0);

    cyc(60);
    chk("pre_reset_nonzero", 16'(bcd != 16'h0000), 16'd1);
    #5 rst = 1'b1;
    #1;
    chk("async_rst_bcd", bcd, 16'h0000);
    chk("async_rst_m_sec", 16'(m_sec), 16'd0);
    chk("async_rst_roll", 16'(rollover), 16'd0);
    cyc(2);
    rst = 1'b0;
    on  = 1'b0;
    cyc(3);
    chk("post_rst_first_tick", 16'(m_sec), 16'd1);
    on = 1'b1;
    cyc(40);
    chk("post_rst_count", bcd, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
